// File: rtl/led4_fade_pwm_driver.sv
// Four-channel LED PWM driver: each channel's brightness ramps one step per
// ramp interval toward full-on or off, so LEDs fade rather than switch.
module led4_fade_pwm_driver #(
    parameter int C_PWM_BITS     = 4,
    parameter int C_TICK_DIV     = 1000,
    parameter int C_RAMP_PERIODS = 1
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic [3:0] LED4bit,
    input  logic       ENABLE,
    output logic [3:0] LED_OUT,
    output logic       BUSY
);

    localparam int MAX_I  = (1 << C_PWM_BITS) - 1;
    localparam int TICK_W = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;
    localparam int RAMP_W = (C_RAMP_PERIODS > 1) ? $clog2(C_RAMP_PERIODS) : 1;

    localparam logic [C_PWM_BITS-1:0] MAX       = C_PWM_BITS'(MAX_I);
    localparam logic [C_PWM_BITS-1:0] PWM_LAST  = C_PWM_BITS'(MAX_I - 1);
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(C_TICK_DIV - 1);
    localparam logic [RAMP_W-1:0]     RAMP_LAST = RAMP_W'(C_RAMP_PERIODS - 1);

    // Move a level one step toward full-on (up=1) or off (up=0), holding at the rails.
    function automatic logic [C_PWM_BITS-1:0] step_level(
        input logic [C_PWM_BITS-1:0] lvl,
        input logic                  up
    );
        if (up) begin
            return (lvl == MAX) ? lvl : lvl + C_PWM_BITS'(1);
        end else begin
            return (lvl == '0) ? lvl : lvl - C_PWM_BITS'(1);
        end
    endfunction

    logic [TICK_W-1:0]     tick_cnt;
    logic [C_PWM_BITS-1:0] pwm_cnt;
    logic [RAMP_W-1:0]     ramp_cnt;
    logic [C_PWM_BITS-1:0] level [4];

    logic tick_en;
    logic period_end;
    logic step_en;

    assign tick_en    = (tick_cnt == TICK_LAST);
    assign period_end = tick_en & (pwm_cnt == PWM_LAST);
    assign step_en    = period_end & (ramp_cnt == RAMP_LAST);

    // Stage 0: prescaler, PWM period counter and ramp interval counter
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tick_cnt <= '0;
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
        end else begin
            tick_cnt <= tick_en ? '0 : tick_cnt + TICK_W'(1);
            if (tick_en) begin
                pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + C_PWM_BITS'(1);
            end
            if (period_end) begin
                ramp_cnt <= (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + RAMP_W'(1);
            end
        end
    end

    // Brightness levels; targets are sampled only when a step fires
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                level[i] <= '0;
            end
        end else if (step_en) begin
            for (int i = 0; i < 4; i++) begin
                level[i] <= step_level(level[i], LED4bit[i]);
            end
        end
    end

    // Stage 1: registered pin drive; the enable gates only the output
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            LED_OUT <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                LED_OUT[i] <= ENABLE & (pwm_cnt < level[i]);
            end
        end
    end

    always_comb begin
        BUSY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (level[i] != (LED4bit[i] ? MAX : '0)) begin
                BUSY = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led4_fade_pwm_driver.sv
// Directed bench for led4_fade_pwm_driver at N=4, tick divider 2, one period per step
// (30-cycle PWM period, one brightness step every 30 cycles).
module tb_led4_fade_pwm_driver;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic [3:0] LED4bit;
    logic       ENABLE;
    logic [3:0] LED_OUT;
    logic       BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    led4_fade_pwm_driver #(
        .C_PWM_BITS    (4),
        .C_TICK_DIV    (2),
        .C_RAMP_PERIODS(1)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .LED4bit(LED4bit),
        .ENABLE (ENABLE),
        .LED_OUT(LED_OUT),
        .BUSY   (BUSY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Clocks n cycles, sampling on each falling edge: LED_OUT[0] high count,
    // and OR / AND of LED_OUT across the samples.
    task automatic run_cycles(input int n, output int highs,
                              output logic [3:0] orv, output logic [3:0] andv);
        highs = 0;
        orv   = 4'b0000;
        andv  = 4'b1111;
        repeat (n) begin
            @(posedge ACLK);
            @(negedge ACLK);
            highs += int'(LED_OUT[0]);
            orv   |= LED_OUT;
            andv  &= LED_OUT;
        end
    endtask

    int         highs;
    logic [3:0] orv, andv, acc;

    initial begin
        ARESET  = 1'b1;
        LED4bit = 4'hF;
        ENABLE  = 1'b1;
        repeat (3) @(negedge ACLK);
        check("rst_led_out", LED_OUT, 0);
        check("rst_busy", BUSY, 1);

        // Fade-in of channel 0 from reset
        ARESET  = 1'b0;
        LED4bit = 4'b0001;
        acc = '0;
        for (int w = 0; w < 16; w++) begin
            run_cycles(30, highs, orv, andv);
            acc |= orv;
            check($sformatf("fadein_high_w%0d", w), highs, 2 * w);
            check($sformatf("fadein_busy_w%0d", w), BUSY, (w < 14) ? 1 : 0);
        end
        check("fadein_full_const", andv[0], 1);
        check("fadein_upper_quiet", acc[3:1], 0);

        // Fade-out from full brightness
        LED4bit = 4'b0000;
        #1;
        check("fadeout_busy_now", BUSY, 1);
        for (int j = 0; j < 16; j++) begin
            run_cycles(30, highs, orv, andv);
            check($sformatf("fadeout_high_w%0d", j), highs, 2 * (15 - j));
            check($sformatf("fadeout_busy_w%0d", j), BUSY, (j < 14) ? 1 : 0);
        end
        check("fadeout_off_const", orv, 0);

        // Reversal mid-ramp
        LED4bit = 4'b0001;
        for (int j = 0; j < 7; j++) begin
            run_cycles(30, highs, orv, andv);
            check($sformatf("rev_up_w%0d", j), highs, 2 * j);
        end
        LED4bit = 4'b0000;
        run_cycles(30, highs, orv, andv);
        check("rev_at7", highs, 14);
        LED4bit = 4'b0001;
        run_cycles(30, highs, orv, andv);
        check("rev_down_to6", highs, 12);
        run_cycles(30, highs, orv, andv);
        check("rev_up_to7", highs, 14);
        run_cycles(30, highs, orv, andv);
        check("rev_at8", highs, 16);

        // Asynchronous reset between edges at level 9
        run_cycles(1, highs, orv, andv);
        check("areset_pre_high", highs, 1);
        #2;
        ARESET  = 1'b1;
        LED4bit = 4'b0000;
        #1;
        check("areset_led_out", LED_OUT, 0);
        check("areset_levels_zero", BUSY, 0);
        LED4bit = 4'b0001;
        #1;
        check("areset_busy_target", BUSY, 1);
        @(negedge ACLK);
        ARESET = 1'b0;
        for (int w = 0; w < 5; w++) begin
            run_cycles(30, highs, orv, andv);
            check($sformatf("after_rst_w%0d", w), highs, 2 * w);
        end

        // Output gate at level 5, held off for three periods
        run_cycles(1, highs, orv, andv);
        check("gate_pre_high", highs, 1);
        ENABLE = 1'b0;
        run_cycles(1, highs, orv, andv);
        check("gate_off_next", orv, 0);
        run_cycles(28, highs, orv, andv);
        check("gate_off_rest", orv, 0);
        for (int w = 0; w < 2; w++) begin
            run_cycles(30, highs, orv, andv);
            check($sformatf("gate_off_w%0d", w), orv, 0);
        end
        ENABLE = 1'b1;
        run_cycles(1, highs, orv, andv);
        check("gate_resume_first", highs, 1);
        run_cycles(29, highs, orv, andv);
        check("gate_resume_level8", highs, 15);

        // Independent channels from reset
        @(negedge ACLK);
        ARESET  = 1'b1;
        LED4bit = 4'b1010;
        @(negedge ACLK);
        check("ind_rst_led_out", LED_OUT, 0);
        ARESET = 1'b0;
        acc = '0;
        for (int w = 0; w < 15; w++) begin
            run_cycles(30, highs, orv, andv);
            acc |= orv;
        end
        check("ind_busy_done", BUSY, 0);
        run_cycles(30, highs, orv, andv);
        acc |= orv;
        check("ind_or", orv, 4'b1010);
        check("ind_and", andv, 4'b1010);
        check("ind_even_quiet", acc & 4'b0101, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
